// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared op codes, size encodings and FSM states for the MEM-stage access unit
package mem_pkg;

  // Load/store op codes, same encoding as the decoder emits
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  // Bus transfer size encodings
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - alignment check, store lane encoding and load formatting
module mem_align
  import mem_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        mis,
  output logic [3:0]  wstrb,
  output logic [1:0]  size,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_fmt
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Select the addressed byte and half-word of the little-endian read word
  always_comb begin
    rbyte = rdata[7:0];
    case (addr)
      2'd0:    rbyte = rdata[7:0];
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      default: rbyte = rdata[31:24];
    endcase
    rhalf = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Per-op size, misalignment, strobes, replicated store lanes and extended load data
  always_comb begin
    mis        = 1'b0;
    wstrb      = 4'b0000;
    size       = SIZE_W;
    wdata_lane = wdata;
    rdata_fmt  = rdata;
    case (aluop)
      EXE_LB_OP: begin
        size      = SIZE_B;
        rdata_fmt = {{24{rbyte[7]}}, rbyte};
      end
      EXE_LBU_OP: begin
        size      = SIZE_B;
        rdata_fmt = {24'd0, rbyte};
      end
      EXE_LH_OP: begin
        size      = SIZE_H;
        mis       = addr[0];
        rdata_fmt = {{16{rhalf[15]}}, rhalf};
      end
      EXE_LHU_OP: begin
        size      = SIZE_H;
        mis       = addr[0];
        rdata_fmt = {16'd0, rhalf};
      end
      EXE_LW_OP: begin
        mis = |addr;
      end
      EXE_SB_OP: begin
        size       = SIZE_B;
        wstrb      = 4'b0001 << addr;
        wdata_lane = {4{wdata[7:0]}};
      end
      EXE_SH_OP: begin
        size       = SIZE_H;
        mis        = addr[0];
        wstrb      = addr[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      EXE_SW_OP: begin
        mis   = |addr;
        wstrb = 4'b1111;
      end
      default: begin
        mis = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data bus initiator with pipeline stall request
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mem_rmem_i,
  input  logic                mem_wmem_i,
  input  logic [7:0]          mem_aluop_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic                mem_excp_i,
  output logic                data_req_o,
  output logic                data_wr_o,
  output logic [1:0]          data_size_o,
  output logic [DATA_W/8-1:0] data_wstrb_o,
  output logic [ADDR_W-1:0]   data_addr_o,
  output logic [DATA_W-1:0]   data_wdata_o,
  input  logic                data_addr_ok_i,
  input  logic                data_data_ok_i,
  input  logic [DATA_W-1:0]   data_rdata_i,
  output logic                stall_req_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                rdata_valid_o,
  output logic                adel_o,
  output logic                ades_o
);

  mem_state_e state, state_n;

  logic              rd_q, wr_q;
  logic [7:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              idle;
  logic              sel_rd, sel_wr;
  logic [7:0]        sel_op;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              mis;
  logic [3:0]        wstrb;
  logic [1:0]        size;
  logic [31:0]       wdata_lane;
  logic [31:0]       rdata_fmt;

  logic              need;
  logic              req_c, stall_c;
  logic              load_done;

  // Live pipeline fields drive the bus in IDLE; the captured copy drives it afterwards
  assign idle      = (state == ST_IDLE);
  assign sel_rd    = idle ? mem_rmem_i  : rd_q;
  assign sel_wr    = idle ? mem_wmem_i  : wr_q;
  assign sel_op    = idle ? mem_aluop_i : op_q;
  assign sel_addr  = idle ? mem_addr_i  : addr_q;
  assign sel_wdata = idle ? mem_wdata_i : wdata_q;

  mem_align u_align (
    .aluop      (sel_op),
    .addr       (sel_addr[1:0]),
    .wdata      (sel_wdata),
    .rdata      (data_rdata_i),
    .mis        (mis),
    .wstrb      (wstrb),
    .size       (size),
    .wdata_lane (wdata_lane),
    .rdata_fmt  (rdata_fmt)
  );

  assign need = (mem_rmem_i | mem_wmem_i) & ~mis & ~mem_excp_i;

  // Next-state and handshake outputs; data_ok before addr_ok is deliberately ignored
  always_comb begin
    state_n = state;
    req_c   = 1'b0;
    stall_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (need) begin
          req_c   = 1'b1;
          stall_c = 1'b1;
          if (data_addr_ok_i && data_data_ok_i) state_n = ST_DONE;
          else if (data_addr_ok_i)              state_n = ST_WAIT;
          else                                  state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (data_addr_ok_i && data_data_ok_i) state_n = ST_DONE;
        else if (data_addr_ok_i)              state_n = ST_WAIT;
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        if (data_data_ok_i) state_n = ST_DONE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign load_done = (state_n == ST_DONE) & sel_rd;

  // Reset forces the handshake low even while the pipeline still presents an access
  assign data_req_o   = req_c & ~rst_i;
  assign stall_req_o  = stall_c & ~rst_i;
  assign data_wr_o    = data_req_o & sel_wr;
  assign data_size_o  = data_req_o ? size : 2'd0;
  assign data_wstrb_o = data_req_o ? wstrb : '0;
  assign data_addr_o  = data_req_o ? sel_addr : '0;
  assign data_wdata_o = data_req_o ? wdata_lane : '0;

  // Address errors are reported only while the access is first presented
  assign adel_o = idle & ~rst_i & mem_rmem_i & mis;
  assign ades_o = idle & ~rst_i & mem_wmem_i & mis;

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Capture the request on leaving IDLE so later cycles do not depend on the pipeline
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      op_q    <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (idle && need) begin
      rd_q    <= mem_rmem_i;
      wr_q    <= mem_wmem_i;
      op_q    <= mem_aluop_i;
      addr_q  <= mem_addr_i;
      wdata_q <= mem_wdata_i;
    end
  end

  // Load result is latched on the completing data_ok and held until the next load
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
    end else begin
      rdata_valid_o <= load_done;
      if (load_done) rdata_o <= rdata_fmt;
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory initiator. It consumes the access fields registered by the EX→MEM pipeline register: read/write enables, ALU op, I/O address and store data.
- Drives a request/address-ok/data-ok data bus, formats load data and detects misaligned accesses.
- Raises a stall request back to pipeline control while a transaction is outstanding. This is the signal that becomes the pipeline register's stall input.

Parameters:
- ADDR_W, 32, data bus address width.
- DATA_W, 32, data bus data width (fixed at 32; byte lanes = DATA_W/8).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- mem_rmem_i  in  1  load instruction in MEM
- mem_wmem_i  in  1  store instruction in MEM
- mem_aluop_i  in  8  op code (LB/LBU/LH/LHU/LW/SB/SH/SW from package)
- mem_addr_i  in  32  effective address
- mem_wdata_i  in  32  store source register value
- mem_excp_i  in  1  exception already pending for this instruction; suppresses access
- data_req_o  out  1  bus request
- data_wr_o  out  1  1 = write
- data_size_o  out  2  0 = byte, 1 = half, 2 = word
- data_wstrb_o  out  4  byte-lane write strobes
- data_addr_o  out  32  bus address
- data_wdata_o  out  32  lane-replicated store data
- data_addr_ok_i  in  1  request accepted
- data_data_ok_i  in  1  transaction complete / read data valid
- data_rdata_i  in  32  read data
- stall_req_o  out  1  hold pipeline
- rdata_o  out  32  formatted load result
- rdata_valid_o  out  1  rdata_o updated this cycle
- adel_o  out  1  load address error
- ades_o  out  1  store address error

Behaviour:
- Clocking and reset: clk_i is the single clock. rst_i is asynchronous active-high. In reset the FSM is IDLE, rdata_o=0 and rdata_valid_o=0, and all bus outputs and stall_req_o are 0.
- Definitions:
  - mis: LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0.
  - need = (rmem|wmem) & !mis & !excp.
- adel_o = rmem & mis; ades_o = wmem & mis. Both are combinational and valid in IDLE only. A misaligned access issues no bus request.
- FSM states and transitions:
  - IDLE: if need, then data_req_o=1 and stall_req_o=1.
    - If addr_ok=1 and data_ok=1 → DONE.
    - Else if addr_ok=1 → WAIT.
    - Else → REQ.
  - REQ: data_req_o=1, stall_req_o=1. Request fields are held from the registered copy captured on leaving IDLE.
    - If addr_ok=1 and data_ok=1 → DONE.
    - Else if addr_ok=1 → WAIT.
  - WAIT: data_req_o=0, stall_req_o=1. On data_ok=1 → DONE.
  - DONE: stall_req_o=0 for exactly one cycle, so the pipeline register advances at the end of this cycle. Next state is IDLE.
- Load capture: on the data_ok=1 edge of a load, rdata_o is loaded with formatted data. rdata_valid_o=1 during DONE. rdata_o holds its value until the next load completes.
- Load formatting (little-endian):
  - LB/LBU: byte at addr[1:0], sign- or zero-extended to 32.
  - LH/LHU: half at addr[1], sign- or zero-extended to 32.
  - LW: passed through unchanged.
- Store encoding:
  - SB: wstrb = 1<<addr[1:0]; wdata = byte×4.
  - SH: wstrb = 0011 (addr[1]=0) or 1100 (addr[1]=1); wdata = half×2.
  - SW: wstrb = 1111.
  - Loads: wstrb = 0000.
- Bus fields: data_addr_o = mem_addr_i with no masking. data_size_o follows the op.
- Exception gating: mem_excp_i is sampled only in IDLE. A transaction already issued always completes.
- data_ok seen in IDLE or REQ before addr_ok is ignored (protocol violation; bench asserts).
- Reset asserted mid-transaction: immediate return to IDLE. Any late data_ok arriving after reset is ignored.

Decomposition:
- Shared package mem_pkg holds:
  - aluop localparams (EXE_LB_OP … EXE_SW_OP), sharing the encoding used by the decoder;
  - size encodings SIZE_B/H/W;
  - the FSM state enum.
- One combinational sub-module, mem_align: op+addr+wdata+rdata → mis, wstrb, size, wdata lanes, formatted rdata.
- The top level holds the FSM and capture registers.

Test Plan:
- LW addr 0x1000, addr_ok in cycle 1, data_ok 3 cycles later with 0xDEADBEEF → stall_req high 4 cycles then low 1; rdata_o=0xDEADBEEF with rdata_valid_o=1 in DONE.
- LB addr 0x1003, rdata 0x80FF_FFFF → rdata_o=0xFFFFFF80. Same access as LBU → 0x00000080.
- SH addr 0x2002, wdata 0x0000ABCD → wstrb=1100, data_wdata_o=0xABCDABCD, data_size_o=1, data_wr_o=1.
- LW addr 0x1002 → adel_o=1, no data_req_o, stall_req_o=0. SW addr 0x2001 → ades_o=1.
- addr_ok and data_ok in the same cycle as the IDLE request → DONE next cycle; total stall exactly 1 cycle.
- rst_i pulsed while in WAIT → outputs zero asynchronously; a later stray data_ok does not change rdata_o.
